// File: rtl/seven_pkg.sv
// Shared codes for the seven-state FSM and its scheduler: FSM state codes,
// requester target codes and the sequencer state type.
package seven_pkg;

  localparam logic [2:0] ST_A = 3'b000;
  localparam logic [2:0] ST_B = 3'b001;
  localparam logic [2:0] ST_C = 3'b101;
  localparam logic [2:0] ST_D = 3'b010;
  localparam logic [2:0] ST_E = 3'b100;
  localparam logic [2:0] ST_F = 3'b110;
  localparam logic [2:0] ST_G = 3'b111;

  localparam logic [1:0] TGT_D = 2'b00;
  localparam logic [1:0] TGT_E = 2'b01;
  localparam logic [1:0] TGT_G = 2'b10;
  localparam logic [1:0] TGT_F = 2'b11;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_GO, SEQ_MID, SEQ_CHK} seq_t;

  // FSM code a walk toward the given target must end in
  function automatic logic [2:0] tgt_code(input logic [1:0] t);
    case (t)
      TGT_D:   tgt_code = ST_D;
      TGT_E:   tgt_code = ST_E;
      TGT_G:   tgt_code = ST_G;
      default: tgt_code = ST_F;
    endcase
  endfunction

endpackage

// File: rtl/seven_rr_arb.sv
// Generic combinational round-robin arbiter: the search starts at ptr and wraps,
// and the first active request wins.
module seven_rr_arb #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  logic [IW-1:0] i;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    i   = '0;
    for (int k = 0; k < N; k++) begin
      i = IW'((int'(ptr) + k) % N);
      if (en && !vld && req[i]) begin
        vld    = 1'b1;
        gnt[i] = 1'b1;
        idx    = i;
      end
    end
  end

endmodule

// File: rtl/seven_sched.sv
// Round-robin scheduler that steers the free-running seven FSM to each requester's
// terminal state. Optional per-requester grant counters via SEVEN_SCHED_STATS_EN.
module seven_sched
  import seven_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int SYNC_TIMEOUT = 8,
  parameter int CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     tgt,
  output logic [N_REQ-1:0]       ack,
  output logic                   err,
  output logic                   err_sync,
  output logic                   busy,
  output logic                   x1,
  output logic                   x2,
  output logic                   x3,
  input  logic [2:0]             state_in,
  input  logic                   z1,
  input  logic                   z2,
  input  logic                   z3
`ifdef SEVEN_SCHED_STATS_EN
  ,
  output logic [CNT_W*N_REQ-1:0] grant_cnt
`endif
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;

  seq_t          st;
  logic [IW-1:0] ptr, gidx, widx;
  logic [1:0]    tgt_q;
  logic [TW-1:0] to_cnt;
  logic [N_REQ-1:0] wgnt;
  logic          wvld, pending, in_ab, to_hit, z_ok;
  logic [2:0]    xv;

  assign pending = |req;
  assign in_ab   = (state_in == ST_A) || (state_in == ST_B);
  assign to_hit  = (st == SEQ_IDLE) && pending && !in_ab &&
                   (to_cnt == TW'(SYNC_TIMEOUT - 1));
  assign err_sync = to_hit;
  assign busy     = (st != SEQ_IDLE);

  // Grants only happen at b, so the next cycle's a is where the walk begins
  seven_rr_arb #(.N(N_REQ)) u_arb (
    .req (req),
    .ptr (ptr),
    .en  ((st == SEQ_IDLE) && (state_in == ST_B)),
    .gnt (wgnt),
    .idx (widx),
    .vld (wvld)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st     <= SEQ_IDLE;
      ptr    <= '0;
      gidx   <= '0;
      tgt_q  <= TGT_D;
      to_cnt <= '0;
    end else begin
      case (st)
        SEQ_IDLE: if (wvld) begin
          st    <= SEQ_GO;
          gidx  <= widx;
          tgt_q <= tgt[{widx, 1'b0} +: 2];
          ptr   <= (widx == IW'(N_REQ - 1)) ? '0 : widx + 1'b1;
        end
        SEQ_GO:  st <= SEQ_MID;
        SEQ_MID: st <= SEQ_CHK;
        default: st <= SEQ_IDLE;
      endcase
      if (st != SEQ_IDLE || !pending || in_ab || to_hit) to_cnt <= '0;
      else                                             to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    case (tgt_q)
      TGT_D:   z_ok = z1;
      TGT_E:   z_ok = z2;
      TGT_G:   z_ok = z3;
      default: z_ok = !(z1 | z2 | z3);
    endcase
  end

  // x is a pure function of registered state and latched target
  always_comb begin
    xv  = 3'b100;
    ack = '0;
    err = 1'b0;
    case (st)
      SEQ_GO:  xv = {tgt_q == TGT_D, 2'b00};
      SEQ_MID: case (tgt_q)
        TGT_D:   xv = 3'b010;
        TGT_E:   xv = 3'b011;
        TGT_G:   xv = 3'b000;
        default: xv = 3'b001;
      endcase
      SEQ_CHK: begin
        ack[gidx] = 1'b1;
        err       = (state_in != tgt_code(tgt_q)) || !z_ok;
      end
      default: xv = 3'b100;
    endcase
  end

  assign {x1, x2, x3} = xv;

`ifdef SEVEN_SCHED_STATS_EN
  logic [N_REQ-1:0][CNT_W-1:0] cnt_q;

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        cnt_q[g] <= '0;
      else if (st == SEQ_CHK && gidx == IW'(g) && cnt_q[g] != '1)
        cnt_q[g] <= cnt_q[g] + 1'b1;
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seven_sched.sv
// Directed and randomized bench for seven_sched; the bench plays the FSM by driving
// state_in/z directly and predicts grants, x walks and err from a transaction model.
module tb_seven_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] req = '0;
  logic [5:0] tgt = '0;
  logic [2:0] ack;
  logic       err, err_sync, busy, x1, x2, x3;
  logic [2:0] state_in = 3'b000;
  logic       z1 = 1'b0, z2 = 1'b0, z3 = 1'b0;
`ifdef SEVEN_SCHED_STATS_EN
  logic [23:0] grant_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // model: who is waiting, their targets, where the next search starts
  logic [2:0] pend;
  logic [1:0] tg [3];
  int         ptr_m;

  always #5 clk = ~clk;

  seven_sched dut (
    .clk(clk), .reset(reset), .req(req), .tgt(tgt), .ack(ack), .err(err),
    .err_sync(err_sync), .busy(busy), .x1(x1), .x2(x2), .x3(x3),
    .state_in(state_in), .z1(z1), .z2(z2), .z3(z3)
`ifdef SEVEN_SCHED_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Walk tables: x during GO/MID, terminal code and the z line that must be high
  function automatic logic [2:0] go_x(input logic [1:0] t);
    return (t == 2'b00) ? 3'b100 : 3'b000;
  endfunction
  function automatic logic [2:0] mid_x(input logic [1:0] t);
    case (t)
      2'b00: return 3'b010;
      2'b01: return 3'b011;
      2'b10: return 3'b000;
      default: return 3'b001;
    endcase
  endfunction
  function automatic logic [2:0] term_of(input logic [1:0] t);
    case (t)
      2'b00: return 3'b010;
      2'b01: return 3'b100;
      2'b10: return 3'b111;
      default: return 3'b110;
    endcase
  endfunction
  function automatic logic [2:0] z_of(input logic [1:0] t);
    case (t)
      2'b00: return 3'b100;
      2'b01: return 3'b010;
      2'b10: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic do_reset;
    reset = 1'b0;
    req = '0;
    state_in = 3'b000;
    {z1, z2, z3} = 3'b000;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", ack, 3'b000);
    chk("rst_err", err, 1'b0);
    chk("rst_err_sync", err_sync, 1'b0);
    chk("rst_x", {x1, x2, x3}, 3'b100);
    tick;
    tick;
    reset = 1'b1;
    pend = '0;
    ptr_m = 0;
  endtask

  // mode 0: correct arrival; 1: random arrival; 2: correct state but z3 forced high
  task automatic txn(input int mode);
    int w;
    logic [1:0] t;
    logic [2:0] s_resp, z_resp;
    logic e_exp;
    req = pend;
    tgt = {tg[2], tg[1], tg[0]};
    state_in = 3'b001;
    {z1, z2, z3} = 3'b000;
    #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_x", {x1, x2, x3}, 3'b100);
    w = -1;
    for (int k = 0; k < 3; k++)
      if (w < 0 && pend[(ptr_m + k) % 3]) w = (ptr_m + k) % 3;
    t = tg[w];
    tick;
    state_in = 3'b000;
    tgt = 6'($urandom);
    #1;
    chk("go_busy", busy, 1'b1);
    chk("go_x", {x1, x2, x3}, go_x(t));
    chk("go_ack", ack, 3'b000);
    tick;
    state_in = (t == 2'b00) ? 3'b001 : 3'b101;
    #1;
    chk("mid_x", {x1, x2, x3}, mid_x(t));
    tick;
    s_resp = term_of(t);
    z_resp = z_of(t);
    if (mode == 1) begin
      if ($urandom_range(1, 0) == 0) s_resp = 3'($urandom);
      if ($urandom_range(1, 0) == 0) z_resp = 3'($urandom);
    end else if (mode == 2) begin
      z_resp = 3'b001;
    end
    e_exp = (s_resp != term_of(t)) ||
            ((t == 2'b11) ? (z_resp != 3'b000) : ((z_resp & z_of(t)) == 3'b000));
    state_in = s_resp;
    {z1, z2, z3} = z_resp;
    #1;
    chk("chk_ack", ack, 3'b001 << w);
    chk("chk_err", err, e_exp);
    chk("chk_x", {x1, x2, x3}, 3'b100);
    tick;
    pend[w] = 1'b0;
    ptr_m = (w + 1) % 3;
    req = pend;
    state_in = 3'b000;
    {z1, z2, z3} = 3'b000;
  endtask

  initial begin
    pend = '0;
    ptr_m = 0;
    for (int i = 0; i < 3; i++) tg[i] = 2'b00;

    do_reset;

    // single d request
    pend = 3'b001; tg[0] = 2'b00;
    txn(0);

    // three simultaneous requests d/e/g, then requester 0 again after the wrap
    do_reset;
    pend = 3'b111; tg[0] = 2'b00; tg[1] = 2'b01; tg[2] = 2'b10;
    txn(0); txn(0); txn(0);
    pend = 3'b001;
    txn(0);

    // target f: clean arrival, then z3 stuck high
    pend = 3'b001; tg[0] = 2'b11;
    txn(0);
    pend = 3'b001;
    txn(2);

    // idle sync timeout: FSM parked at c with a request pending
    do_reset;
    pend = 3'b001; req = pend; tg[0] = 2'b01; tgt = 6'b000001;
    state_in = 3'b101;
    for (int c = 1; c <= 9; c++) begin
      #1;
      chk("sync_pulse", err_sync, c == 8);
      chk("sync_busy", busy, 1'b0);
      tick;
    end
    state_in = 3'b000;
    #1;
    chk("sync_clear", err_sync, 1'b0);
    tick;
    state_in = 3'b101;
    for (int c = 1; c <= 7; c++) begin
      #1;
      chk("sync_restart", err_sync, 1'b0);
      tick;
    end
    state_in = 3'b000;
    tick;
    txn(0);

    // reset during MID, then the still-pending request is served from a clean start
    do_reset;
    pend = 3'b001; tg[0] = 2'b01;
    req = pend; tgt = 6'b000001; state_in = 3'b001;
    tick;
    state_in = 3'b000;
    tick;
    state_in = 3'b101;
    #1;
    chk("mid_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_ack", ack, 3'b000);
    chk("rstmid_err", err, 1'b0);
    chk("rstmid_x", {x1, x2, x3}, 3'b100);
    tick;
    reset = 1'b1;
    ptr_m = 0;
    state_in = 3'b000;
    tick;
    #1;
    chk("rstmid_no_grant_at_a", busy, 1'b0);
    txn(0);

    // randomized traffic with random arrival quality
    for (int n = 0; n < 40; n++) begin
      pend = pend | 3'($urandom);
      if (pend == 3'b000) pend = 3'b001 << $urandom_range(2, 0);
      for (int i = 0; i < 3; i++) tg[i] = 2'($urandom);
      txn(int'($urandom_range(1, 0)));
    end

`ifdef SEVEN_SCHED_STATS_EN
    do_reset;
    for (int n = 0; n < 300; n++) begin
      pend = 3'b010;
      tg[1] = 2'($urandom);
      txn(0);
    end
    #1;
    chk("grant_cnt_sat", grant_cnt, {8'd0, 8'd255, 8'd0});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
